// File: rtl/command_issue_arbiter.sv
// Command issue arbiter: round-robin grant of NUM_REQ requesters onto the
// single PSL command interface. Issue is gated on credits and on a free tag.
// The block owns the tag free-list and the credit counter.
module command_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_W    = 96,
  parameter int NUM_TAGS     = 32,
  parameter int INIT_CREDITS = 64
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           enabled_in,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           cmd_valid,
  output logic [PAYLOAD_W-1:0]           cmd_payload,
  output logic [7:0]                     cmd_tag,
  output logic [2:0]                     cmd_src,
  input  logic                           credit_return,
  input  logic                           tag_release_valid,
  input  logic [7:0]                     tag_release,
  output logic [6:0]                     credits,
  output logic [8:0]                     outstanding,
  output logic                           error
);

  logic                 r_en;
  logic [NUM_TAGS-1:0]  r_free;
  logic [6:0]           r_credits;
  logic [8:0]           r_out;
  logic                 r_err;
  logic [2:0]           r_ptr;
  logic                 r_cmd_valid;
  logic [PAYLOAD_W-1:0] r_cmd_payload;
  logic [7:0]           r_cmd_tag;
  logic [2:0]           r_cmd_src;

  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_any;
  logic [2:0]           w_gsrc;
  logic [2:0]           w_ptr_nxt;
  logic [PAYLOAD_W-1:0] w_pay;
  logic [7:0]           w_tag;
  logic                 w_tag_ok;
  logic                 w_rel_ok;
  logic                 w_rel_err;
  logic                 w_issue;
  logic [NUM_TAGS-1:0]  w_free_nxt;
  logic [6:0]           w_cred_nxt;
  logic                 w_cred_err;

  // Round-robin scan: first valid requester at or above the pointer, wrapping.
  always_comb begin
    w_gnt     = '0;
    w_any     = 1'b0;
    w_gsrc    = '0;
    w_ptr_nxt = r_ptr;
    w_pay     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_any && req_valid[j] && (j == ((int'(r_ptr) + k) % NUM_REQ))) begin
          w_any     = 1'b1;
          w_gnt[j]  = 1'b1;
          w_gsrc    = 3'(j);
          w_pay     = req_payload[j*PAYLOAD_W +: PAYLOAD_W];
          w_ptr_nxt = 3'((j + 1) % NUM_REQ);
        end
      end
    end
  end

  // Lowest-index free tag, taken from the pre-release free set.
  always_comb begin
    w_tag    = '0;
    w_tag_ok = 1'b0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (r_free[t]) begin
        w_tag    = 8'(t);
        w_tag_ok = 1'b1;
      end
    end
  end

  // A release is honoured only for an in-range tag that is currently busy.
  always_comb begin
    w_rel_ok = 1'b0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (tag_release_valid && (tag_release == 8'(t)) && !r_free[t]) w_rel_ok = 1'b1;
    end
    w_rel_err = tag_release_valid && !w_rel_ok;
  end

  assign w_issue   = r_en && (r_credits != 7'd0) && w_tag_ok && w_any;
  assign req_ready = w_issue ? w_gnt : '0;

  // Next free set: release and allocation never hit the same tag in one cycle.
  always_comb begin
    w_free_nxt = r_free;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (w_rel_ok && (tag_release == 8'(t))) w_free_nxt[t] = 1'b1;
      if (w_issue && (w_tag == 8'(t)))        w_free_nxt[t] = 1'b0;
    end
  end

  // Credit counter; a return at the ceiling with no issue saturates and flags.
  always_comb begin
    w_cred_nxt = r_credits;
    w_cred_err = 1'b0;
    if (w_issue && !credit_return) begin
      w_cred_nxt = r_credits - 7'd1;
    end else if (!w_issue && credit_return) begin
      if (r_credits == 7'(INIT_CREDITS)) w_cred_err = 1'b1;
      else                               w_cred_nxt = r_credits + 7'd1;
    end
  end

  // State and registered command outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_en          <= 1'b0;
      r_free        <= '1;
      r_credits     <= 7'(INIT_CREDITS);
      r_out         <= '0;
      r_err         <= 1'b0;
      r_ptr         <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_payload <= '0;
      r_cmd_tag     <= '0;
      r_cmd_src     <= '0;
    end else begin
      r_en        <= enabled_in;
      r_free      <= w_free_nxt;
      r_credits   <= w_cred_nxt;
      r_out       <= r_out + 9'(w_issue) - 9'(w_rel_ok);
      r_err       <= r_err | w_rel_err | w_cred_err;
      r_cmd_valid <= w_issue;
      if (w_issue) begin
        r_ptr         <= w_ptr_nxt;
        r_cmd_payload <= w_pay;
        r_cmd_tag     <= w_tag;
        r_cmd_src     <= w_gsrc;
      end
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_payload = r_cmd_payload;
  assign cmd_tag     = r_cmd_tag;
  assign cmd_src     = r_cmd_src;
  assign credits     = r_credits;
  assign outstanding = r_out;
  assign error       = r_err;

endmodule

// File: doc/command_issue_arbiter.md
Name: command_issue_arbiter

Overview:
- Shares the single PSL command interface between NUM_REQ requesters (read engine, write engine, prefetch, restart).
- Sits directly upstream of the command output stage and drives its command-buffer-line and tag inputs.
- Round-robin arbitration, gated on PSL command credits and on a free command tag.
- Owns the tag free-list and the credit counter; tags and credits return on response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PAYLOAD_W, 96, width of one packed command payload (command, address, size, abt).
- NUM_TAGS, 32, number of command tags in use (≤256); tags are 0..NUM_TAGS-1.
- INIT_CREDITS, 64, credits loaded at reset; also the saturation ceiling.

Ports:
- clock  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enabled_in  in  1  issue enable; registered once internally.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_payload  in  NUM_REQ*PAYLOAD_W  packed payloads; requester i occupies slice i.
- req_ready  out  NUM_REQ  one-hot acceptance pulse for the granted requester.
- cmd_valid  out  1  command valid to output stage.
- cmd_payload  out  PAYLOAD_W  granted payload.
- cmd_tag  out  8  allocated tag.
- cmd_src  out  3  index of the granted requester.
- credit_return  in  1  one credit returned this cycle.
- tag_release_valid  in  1  response retires a tag.
- tag_release  in  8  tag being retired.
- credits  out  7  current credit count.
- outstanding  out  9  number of tags in flight.
- error  out  1  sticky protocol error.

Behaviour:
- Reset (rst high at a clock edge):
  - cmd_valid=0, req_ready=0, cmd_tag=0, cmd_src=0, cmd_payload=0.
  - credits=INIT_CREDITS, all tags free, outstanding=0, error=0, round-robin pointer=0, internal enable=0.
- Reset mid-operation discards in-flight state completely; no tags or credits are remembered.
- Issue condition in cycle t, all of the following true:
  - internal enable = 1;
  - credits > 0;
  - at least one free tag;
  - some req_valid bit = 1.
- Grant and latency:
  - Grant goes to the first valid requester scanning from the pointer upward, with wrap-around.
  - req_ready[g] pulses combinationally in cycle t; that is the handshake, and the requester drops or advances its payload next cycle.
  - At edge t+1: cmd_valid=1, cmd_payload=slice g, cmd_src=g, cmd_tag=lowest-index free tag. That tag is marked busy, credits decrements, and the pointer becomes (g+1) mod NUM_REQ.
  - Latency from request to cmd_valid is 1 cycle.
  - Back-to-back issue every cycle is allowed while resources last.
- No issue: cmd_valid=0 at the next edge; payload and tag hold their last values.
  - req_ready stays 0 while credits=0, no tag is free, or enable is low.
- Credits:
  - credit_return adds 1, and an issue subtracts 1.
  - Issue and return in the same cycle leave credits unchanged; issue is allowed even at credits=1.
  - A return at credits=INIT_CREDITS with no issue saturates (no change) and sets error.
- Tags:
  - tag_release frees the tag at the next edge.
  - Release and allocation in the same cycle: allocation uses the pre-release free set, so the released tag is not reissued that cycle.
  - Releasing a tag that is already free, or a tag ≥ NUM_TAGS, is ignored and sets error.
- outstanding = count of busy tags, updated with the same edge semantics as the tag set.
- error: cleared only by rst.
- Width rule: requester index is zero-extended to 3 bits on cmd_src.

Test Plan:
- Reset, enabled_in=1, req_valid=4'b0001 payload A -> cmd_valid at cycle 2 (1-cycle enable register plus 1), cmd_tag=0, cmd_src=0, credits=63, outstanding=1.
- req_valid=4'b1111 held 8 cycles, no responses -> cmd_src sequence 0,1,2,3,0,1,2,3; tags 0..7; credits=56.
- INIT_CREDITS=4, 6 requests, no credit_return -> exactly 4 issues, req_ready=0 afterwards; one credit_return -> one more issue with next tag.
- Issue all 32 tags, release tag 5 with a pending request the same cycle -> no issue that cycle; next cycle issues tag 5.
- Release already-free tag 9, or credit_return at credits=64 -> error=1 and stays 1; credits stays 64.
- Assert rst while outstanding=10 and credits=54 -> next cycle credits=64, outstanding=0, cmd_valid=0, next grant gets tag 0 from requester 0.
